// File: rtl/alu_program_memory.sv
// Unified program/data memory beside simple_ALU with a streaming loader.
// Define MEM_WR_FORWARD_EN for write-first reads on ALU writes.
module alu_program_memory #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [15:0]       i_memAddr,
    input  logic [DATA_W-1:0] i_memData,
    input  logic              i_memWrEnable,
    output logic [DATA_W-1:0] o_memData,
    input  logic              i_loadValid,
    input  logic [DATA_W-1:0] i_loadData,
    input  logic              i_loadLast,
    output logic              o_loadReady,
    output logic [ADDR_W:0]   o_loadCount,
    output logic              o_cpuRst
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        LOAD,
        RELEASE,
        RUN
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              ld_xfer;
    logic              alu_wr;
    logic              unused_addr;

    assign addr        = i_memAddr[ADDR_W-1:0];
    assign unused_addr = ^i_memAddr[15:ADDR_W];

    always_comb begin
        state_nx    = state;
        o_loadReady = 1'b0;
        o_cpuRst    = 1'b1;
        ld_xfer     = 1'b0;
        alu_wr      = 1'b0;
        unique case (state)
            LOAD: begin
                o_loadReady = 1'b1;
                ld_xfer     = i_loadValid;
                // Last word flagged or top address written ends the load
                if (ld_xfer && (i_loadLast || (&ptr)))
                    state_nx = RELEASE;
            end
            RELEASE: begin
                state_nx = RUN;
            end
            RUN: begin
                o_cpuRst = 1'b0;
                alu_wr   = i_memWrEnable;
            end
            default: begin
                state_nx = LOAD;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= LOAD;
            ptr         <= '0;
            o_loadCount <= '0;
        end else begin
            state <= state_nx;
            if (ld_xfer) begin
                if (!(&ptr))
                    ptr <= ptr + 1'b1;
                if (o_loadCount != (ADDR_W+1)'(DEPTH))
                    o_loadCount <= o_loadCount + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (ld_xfer)
                mem[ptr] <= i_loadData;
            else if (alu_wr)
                mem[addr] <= i_memData;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_memData <= '0;
        end else begin
`ifdef MEM_WR_FORWARD_EN
            o_memData <= alu_wr ? i_memData : mem[addr];
`else
            o_memData <= mem[addr];
`endif
        end
    end

endmodule

// File: tb/tb_alu_program_memory.sv
// Randomized self-checking bench for alu_program_memory.
// Reference model: plain word array plus load bookkeeping.
module tb_alu_program_memory;

    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int DEPTH = 64;
`ifdef MEM_WR_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [15:0]   i_memAddr;
    logic [DW-1:0] i_memData;
    logic          i_memWrEnable;
    logic [DW-1:0] o_memData;
    logic          i_loadValid;
    logic [DW-1:0] i_loadData;
    logic          i_loadLast;
    logic          o_loadReady;
    logic [AW:0]   o_loadCount;
    logic          o_cpuRst;

    int tests = 0;
    int errs  = 0;

    logic [DW-1:0] m     [DEPTH];
    bit            known [DEPTH];

    alu_program_memory #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_memAddr     (i_memAddr),
        .i_memData     (i_memData),
        .i_memWrEnable (i_memWrEnable),
        .o_memData     (o_memData),
        .i_loadValid   (i_loadValid),
        .i_loadData    (i_loadData),
        .i_loadLast    (i_loadLast),
        .o_loadReady   (o_loadReady),
        .o_loadCount   (o_loadCount),
        .o_cpuRst      (o_cpuRst)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic xfer(input logic [DW-1:0] d, input bit last, input int idx);
        i_loadValid = 1'b1;
        i_loadData  = d;
        i_loadLast  = last;
        cycle();
        i_loadValid = 1'b0;
        i_loadLast  = 1'b0;
        m[idx]      = d;
        known[idx]  = 1'b1;
    endtask

    task automatic do_reset();
        i_rst       = 1'b1;
        i_loadValid = 1'b0;
        i_memWrEnable = 1'b0;
        i_memAddr   = 16'h0;
        cycle();
        check("rst_cnt", 32'(o_loadCount), 32'd0);
        check("rst_rdy", 32'(o_loadReady), 32'd1);
        check("rst_cpu", 32'(o_cpuRst), 32'd1);
        check("rst_rd", 32'(o_memData), 32'd0);
        i_rst = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] a, input bit we,
                          input logic [DW-1:0] d);
        int      idx;
        logic [DW-1:0] exp;
        bit      chk;
        idx           = int'(a[AW-1:0]);
        i_memAddr     = a;
        i_memWrEnable = we;
        i_memData     = d;
        cycle();
        chk = known[idx];
        exp = m[idx];
        if (we && FWD) begin
            chk = 1'b1;
            exp = d;
        end
        if (chk)
            check($sformatf("rd_%0d", idx), 32'(o_memData), 32'(exp));
        if (we) begin
            m[idx]     = d;
            known[idx] = 1'b1;
        end
        i_memWrEnable = 1'b0;
        i_memAddr     = 16'h0;
    endtask

    task automatic to_run();
        check("rel_rdy", 32'(o_loadReady), 32'd0);
        check("rel_cpu", 32'(o_cpuRst), 32'd1);
        i_memAddr = 16'h0;
        cycle();
        check("run_cpu", 32'(o_cpuRst), 32'd0);
        if (known[0])
            check("run_rd0", 32'(o_memData), 32'(m[0]));
    endtask

    initial begin
        logic [15:0] w3 [3];
        w3[0] = 16'h8041;
        w3[1] = 16'h0000;
        w3[2] = 16'h1234;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        i_memData  = '0;
        i_loadData = '0;
        i_loadLast = 1'b0;

        // Three-word load
        do_reset();
        for (int i = 0; i < 3; i++) begin
            xfer(w3[i], i == 2, i);
            check("cnt3", 32'(o_loadCount), 32'(i + 1));
        end
        to_run();
        check("first_rd", 32'(o_memData), 32'h8041);

        // Full 64-word stream with ALU write attempts during load
        do_reset();
        i_memWrEnable = 1'b1;
        i_memAddr     = 16'h0002;
        i_memData     = 16'h5555;
        for (int i = 0; i < DEPTH; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                cycle();
                if (g == 0)
                    check("gap_cnt", 32'(o_loadCount), 32'(i));
            end
            i_memWrEnable = 1'b1;
            i_memAddr     = 16'h0002;
            i_memData     = 16'h5555;
            xfer(DW'(i * 3), 1'b0, i);
            i_memWrEnable = (i != DEPTH - 1);
            if (i == 31 || i == DEPTH - 1)
                check("cnt64", 32'(o_loadCount), 32'(i + 1));
        end
        i_memWrEnable = 1'b0;
        to_run();
        i_loadValid = 1'b1;
        i_loadLast  = 1'b1;
        cycle();
        check("run_rdy", 32'(o_loadReady), 32'd0);
        check("run_cnt", 32'(o_loadCount), 32'd64);
        i_loadValid = 1'b0;
        i_loadLast  = 1'b0;
        check("m2_loader", 32'(m[2]), 32'd6);
        for (int i = 0; i < DEPTH; i++)
            run_op({$urandom_range(0, 1023), 6'(i)}, 1'b0, '0);
        check("m63", 32'(m[63]), 32'd189);

        // Upper address bits ignored, one-cycle latency
        run_op(16'h0005, 1'b1, 16'hBEEF);
        run_op(16'h0045, 1'b0, 16'h0000);
        check("beef", 32'(o_memData), 32'hBEEF);

        // Same-address read/write
        run_op(16'h0007, 1'b1, 16'h0001);
        run_op(16'h0007, 1'b1, 16'h00FF);
        check("rw7", 32'(o_memData), FWD ? 32'h00FF : 32'h0001);
        run_op(16'h0007, 1'b0, 16'h0000);

        for (int i = 0; i < 40; i++)
            run_op(16'($urandom), $urandom_range(0, 1) == 1, 16'($urandom));

        // Reset in the middle of a load
        do_reset();
        xfer(16'h1111, 1'b0, 0);
        xfer(16'h2222, 1'b0, 1);
        check("mid_cnt", 32'(o_loadCount), 32'd2);
        do_reset();
        xfer(16'hAAAA, 1'b1, 0);
        check("reload_cnt", 32'(o_loadCount), 32'd1);
        to_run();
        run_op(16'h0000, 1'b0, '0);
        check("m0_reload", 32'(o_memData), 32'hAAAA);
        run_op(16'h0001, 1'b0, '0);
        check("m1_kept", 32'(o_memData), 32'h2222);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
